plaintext_block_packer: RTL and testbench
=========================================

# plaintext_block_packer

Byte-to-block packer on the input side of the AES engine. Buffers the 8-bit byte stream from the USB receive path in an internal byte FIFO, packs 16 consecutive bytes into one 128-bit block, and presents it to the AES core with a valid/ready handshake. A flush request pads a trailing partial block, PKCS#7 style, so the end of a transfer always reaches the cipher.

## Interface
- FIFO_DEPTH, 32: byte FIFO capacity; power of two, minimum 16.
- PTR_W, 5: log2(FIFO_DEPTH).

- clk  in  1  system clock, rising edge.
- n_rst  in  1  asynchronous active-low reset.
- w_enable  in  1  byte write strobe from the USB receive path.
- w_data  in  8  byte written when w_enable=1.
- flush  in  1  single-cycle pulse marking end of transfer.
- block_ready  in  1  AES core accepts block_data.
- block_data  out  128  assembled block; byte k in [8k+7:8k].
- block_valid  out  1  block_data holds a complete block.
- full  out  1  FIFO holds FIFO_DEPTH bytes.
- fifo_count  out  PTR_W+1  FIFO occupancy.
- overflow  out  1  sticky flag: a write was dropped.

## Operation
- Reset values: block_data=0, block_valid=0, full=0, fifo_count=0, overflow=0, lane index idx=0, flush_pending=0, state IDLE.
- Any reset, including mid-block, discards all buffered bytes and any partial block.
- **FIFO**
  - Circular buffer with PTR_W-bit pointers that wrap modulo FIFO_DEPTH.
  - A write is accepted when w_enable=1 and full=0, where full is the value at the start of the cycle.
  - When full=1, a write is dropped and overflow is set. This holds even if a pop occurs in the same cycle.
  - A simultaneous accepted write and pop leave fifo_count unchanged.
- **flush**
  - A flush pulse sets flush_pending.
  - Bytes written in the same cycle as flush belong to the flushed transfer.
- **FSM: IDLE, GATHER, PAD, HOLD**
  - IDLE:
    - If the FIFO is not empty, go to GATHER.
    - Else if flush_pending=1, clear flush_pending and stay in IDLE; no block is emitted.
  - GATHER:
    - If the FIFO is not empty, pop one byte into lane idx and increment idx.
    - A pop with idx=15 goes to HOLD.
    - If the FIFO is empty, flush_pending=1 and idx>0, go to PAD.
    - If the FIFO is empty, flush_pending=1 and idx=0, clear flush_pending and go to IDLE.
  - PAD:
    - Lasts one cycle.
    - Fills lanes idx..15 with the value 16-idx.
    - Clears flush_pending and goes to HOLD.
  - HOLD:
    - block_valid=1; block_data stays stable.
    - On block_valid & block_ready, go to IDLE, set idx=0 and clear block_data to 0.
- A transfer that is an exact multiple of 16 bytes gets no extra pad block.
- A flush pulse arriving while flush_pending=1 has no additional effect.
- The FIFO keeps accepting writes during PAD and HOLD.

## Timing
- FIFO data written at edge t is poppable in the cycle after edge t.
- With 16 consecutive writes starting in cycle 0:
  - bytes are popped at edges 1–16;
  - block_valid rises in cycle 17.
- Latency from the first write strobe to block_valid is 17 cycles.
- Flush path: last byte popped at edge n, PAD in the next cycle, block_valid one cycle after PAD.
- Handshake completes at the edge where block_valid=1 and block_ready=1. block_valid is 0 in the following cycle, so there is a minimum one-cycle gap between blocks.
- Sustained throughput is one block per 18 cycles.
- fifo_count and full are registered and reflect all writes and pops up to and including the previous edge.

## Test plan
- Write 0x00..0x0F on 16 consecutive cycles with block_ready=1 -> block_valid high in cycle 17 only, block_data=128'h0F0E0D0C0B0A09080706050403020100.
- Write 5 bytes 0xA1..0xA5, then pulse flush -> one block: lanes 0–4 = A1..A5, lanes 5–15 = 0x0B.
- Pulse flush with the FIFO empty and idx=0 -> no block_valid for 20 cycles, flush_pending cleared. Write 16 bytes then flush -> exactly one block, no pad block.
- block_ready=0, write 49 consecutive bytes -> first block held in HOLD, full=1 and fifo_count=32, 49th byte dropped, overflow=1. Raise block_ready -> blocks 2 and 3 hold bytes 16–47 in order.
- Hold block_ready=0 for 10 cycles during HOLD -> block_data stable. Pulse ready -> block_valid=0 next cycle, the next block follows with the one-cycle gap.
- Write 8 bytes, assert n_rst mid-GATHER -> all outputs 0 immediately. Release reset, write 0x10..0x1F -> block contains only the new bytes.

Source files
------------

// File: rtl/plaintext_block_packer.sv
// Purpose: buffer USB receive bytes in a circular FIFO, pack 16 of them into a 128-bit AES block, and PKCS#7-pad a trailing partial block when flush is pulsed.
// Latency: 17 cycles from the first write strobe to block_valid; sustained rate is one block per 18 cycles.
// Backpressure: block_valid holds until block_ready; the FIFO keeps filling meanwhile, and writes arriving while full are dropped with a sticky overflow flag.
module plaintext_block_packer #(
    parameter int FIFO_DEPTH = 32,
    parameter int PTR_W      = 5
) (
    input  logic             clk,
    input  logic             n_rst,
    input  logic             w_enable,
    input  logic [7:0]       w_data,
    input  logic             flush,
    input  logic             block_ready,
    output logic [127:0]     block_data,
    output logic             block_valid,
    output logic             full,
    output logic [PTR_W:0]   fifo_count,
    output logic             overflow
);

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_GATHER = 2'd1;
    localparam logic [1:0] ST_PAD    = 2'd2;
    localparam logic [1:0] ST_HOLD   = 2'd3;

    localparam logic [PTR_W:0] DEPTH_CNT = (PTR_W + 1)'(FIFO_DEPTH);

    // Byte storage. It has no reset: the pointers and count decide what is
    // valid, so clearing them is enough to discard buffered bytes.
    logic [7:0]       fifo_mem_q [FIFO_DEPTH];

    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [PTR_W:0]   count_q, count_d;
    logic             full_q, full_d;
    logic             overflow_q, overflow_d;
    logic [3:0]       idx_q, idx_d;
    logic             flush_pending_q, flush_pending_d;
    logic [1:0]       state_q, state_d;
    logic [127:0]     block_q, block_d;

    logic             wr_accept;
    logic             fifo_empty;
    logic             pop;
    logic             fp_clr;
    logic [7:0]       pop_data;

    // full_q reflects occupancy at the start of the cycle, so a write that
    // lands on a full FIFO is dropped even if a pop frees a slot this cycle.
    assign wr_accept  = w_enable & ~full_q;
    assign fifo_empty = (count_q == '0);
    assign pop_data   = fifo_mem_q[rd_ptr_q];

    // Store accepted bytes at the write pointer.
    always_ff @(posedge clk) begin
        if (wr_accept) begin
            fifo_mem_q[wr_ptr_q] <= w_data;
        end
    end

    // FIFO pointers, occupancy, registered full, and the sticky overflow flag.
    always_comb begin
        wr_ptr_d   = wr_ptr_q + PTR_W'(wr_accept);
        rd_ptr_d   = rd_ptr_q + PTR_W'(pop);
        count_d    = count_q + (PTR_W + 1)'(wr_accept) - (PTR_W + 1)'(pop);
        full_d     = (count_d == DEPTH_CNT);
        overflow_d = overflow_q | (w_enable & full_q);
    end

    // Packing FSM: gather 16 lanes, pad a partial block on flush, then hold
    // the block until the AES core takes it.
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        block_d = block_q;
        pop     = 1'b0;
        fp_clr  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                // Looking at the incoming write as well as the stored count
                // lets the first byte of a burst be popped in the very next
                // cycle, which is what keeps first-block latency at 17.
                if (!fifo_empty || wr_accept) begin
                    state_d = ST_GATHER;
                end else if (flush_pending_q) begin
                    fp_clr = 1'b1;
                end
            end
            ST_GATHER: begin
                if (!fifo_empty) begin
                    pop = 1'b1;
                    block_d[{idx_q, 3'b000} +: 8] = pop_data;
                    idx_d = idx_q + 4'd1;
                    if (idx_q == 4'd15) begin
                        state_d = ST_HOLD;
                    end
                end else if (flush_pending_q) begin
                    if (idx_q != 4'd0) begin
                        state_d = ST_PAD;
                    end else begin
                        // Transfer ended on a block boundary: nothing to pad.
                        fp_clr  = 1'b1;
                        state_d = ST_IDLE;
                    end
                end
            end
            ST_PAD: begin
                for (int k = 0; k < 16; k++) begin
                    if (k >= int'(idx_q)) begin
                        block_d[k*8 +: 8] = 8'd16 - {4'd0, idx_q};
                    end
                end
                fp_clr  = 1'b1;
                state_d = ST_HOLD;
            end
            ST_HOLD: begin
                if (block_ready) begin
                    state_d = ST_IDLE;
                    idx_d   = 4'd0;
                    block_d = '0;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // A new flush pulse takes priority over a clear in the same cycle, so an
    // end-of-transfer marker is never lost.
    always_comb begin
        flush_pending_d = (flush_pending_q & ~fp_clr) | flush;
    end

    // State registers; any reset discards buffered bytes and any partial block.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            wr_ptr_q        <= '0;
            rd_ptr_q        <= '0;
            count_q         <= '0;
            full_q          <= 1'b0;
            overflow_q      <= 1'b0;
            idx_q           <= 4'd0;
            flush_pending_q <= 1'b0;
            state_q         <= ST_IDLE;
            block_q         <= '0;
        end else begin
            wr_ptr_q        <= wr_ptr_d;
            rd_ptr_q        <= rd_ptr_d;
            count_q         <= count_d;
            full_q          <= full_d;
            overflow_q      <= overflow_d;
            idx_q           <= idx_d;
            flush_pending_q <= flush_pending_d;
            state_q         <= state_d;
            block_q         <= block_d;
        end
    end

    assign block_data  = block_q;
    assign block_valid = (state_q == ST_HOLD);
    assign full        = full_q;
    assign fifo_count  = count_q;
    assign overflow    = overflow_q;

endmodule

// File: tb/tb_plaintext_block_packer.sv
// Bench for plaintext_block_packer: directed scenarios plus randomized transfers.
// Expected blocks come from a byte-stream model: chop into 16-byte groups, PKCS#7-pad a flushed tail.
// Inputs change 1 time unit after the rising edge; outputs are sampled on the falling edge.
module tb_plaintext_block_packer;
    localparam int FIFO_DEPTH = 32;
    localparam int PTR_W      = 5;

    logic           clk;
    logic           n_rst;
    logic           w_enable;
    logic [7:0]     w_data;
    logic           flush;
    logic           block_ready;
    logic [127:0]   block_data;
    logic           block_valid;
    logic           full;
    logic [PTR_W:0] fifo_count;
    logic           overflow;

    int checks = 0;
    int errors = 0;

    logic [127:0] exp_q[$];
    logic [127:0] obs_q[$];
    logic [7:0]   xfer_q[$];

    plaintext_block_packer #(.FIFO_DEPTH(FIFO_DEPTH), .PTR_W(PTR_W)) dut (
        .clk(clk), .n_rst(n_rst), .w_enable(w_enable), .w_data(w_data),
        .flush(flush), .block_ready(block_ready), .block_data(block_data),
        .block_valid(block_valid), .full(full), .fifo_count(fifo_count),
        .overflow(overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Record every block handed over to the AES core.
    always @(negedge clk) begin
        if (n_rst === 1'b1 && block_valid === 1'b1 && block_ready === 1'b1) begin
            obs_q.push_back(block_data);
        end
    end

    task automatic drive(input logic we, input logic [7:0] d, input logic fl, input logic rdy);
        @(posedge clk);
        #1;
        w_enable    = we;
        w_data      = d;
        flush       = fl;
        block_ready = rdy;
    endtask

    task automatic do_reset();
        n_rst = 1'b0; w_enable = 1'b0; w_data = 8'h00; flush = 1'b0; block_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        n_rst = 1'b1;
        exp_q.delete(); obs_q.delete(); xfer_q.delete();
    endtask

    // Reference: accepted bytes of a transfer, grouped 16 per block; a flushed
    // tail of n bytes is completed with (16-n) copies of the value 16-n.
    function automatic void model_transfer(input bit flushed);
        logic [127:0] blk;
        int n;
        while (xfer_q.size() >= 16) begin
            for (int k = 0; k < 16; k++) blk[8*k +: 8] = xfer_q.pop_front();
            exp_q.push_back(blk);
        end
        if (flushed && xfer_q.size() > 0) begin
            n = xfer_q.size();
            for (int k = 0; k < 16; k++) begin
                if (k < n) blk[8*k +: 8] = xfer_q.pop_front();
                else       blk[8*k +: 8] = 8'(16 - n);
            end
            exp_q.push_back(blk);
        end
    endfunction

    task automatic test_reset();
        n_rst = 1'b0; w_enable = 1'b0; w_data = 8'h00; flush = 1'b0; block_ready = 1'b0;
        #2;
        checks++; if (block_data !== 128'h0) begin errors++; $display("FAIL reset_block_data got %h exp 0", block_data); end
        checks++; if (block_valid !== 1'b0) begin errors++; $display("FAIL reset_block_valid got %b exp 0", block_valid); end
        checks++; if (full !== 1'b0) begin errors++; $display("FAIL reset_full got %b exp 0", full); end
        checks++; if (fifo_count !== '0) begin errors++; $display("FAIL reset_fifo_count got %0d exp 0", fifo_count); end
        checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL reset_overflow got %b exp 0", overflow); end
        do_reset();
    endtask

    task automatic test_basic();
        do_reset();
        for (int c = 0; c <= 20; c++) begin
            drive(c < 16, 8'(c), 1'b0, 1'b1);
            @(negedge clk);
            checks++;
            if (block_valid !== (c == 17)) begin
                errors++; $display("FAIL basic_valid cycle %0d got %b exp %b", c, block_valid, c == 17);
            end
            if (c == 17) begin
                checks++;
                if (block_data !== 128'h0F0E0D0C0B0A09080706050403020100) begin
                    errors++; $display("FAIL basic_data got %h exp 0F0E0D0C0B0A09080706050403020100", block_data);
                end
            end
        end
    endtask

    task automatic test_flush_partial();
        do_reset();
        for (int i = 0; i < 5; i++) begin
            drive(1'b1, 8'hA1 + 8'(i), 1'b0, 1'b1);
            xfer_q.push_back(8'hA1 + 8'(i));
        end
        drive(1'b0, 8'h00, 1'b1, 1'b1);
        model_transfer(1'b1);
        for (int c = 0; c < 60 && obs_q.size() < 1; c++) drive(1'b0, 8'h00, 1'b0, 1'b1);
        repeat (10) drive(1'b0, 8'h00, 1'b0, 1'b1);
        checks++;
        if (obs_q.size() != 1) begin
            errors++; $display("FAIL pad_block_count got %0d exp 1", obs_q.size());
        end else begin
            checks++;
            if (obs_q[0] !== exp_q[0]) begin errors++; $display("FAIL pad_model got %h exp %h", obs_q[0], exp_q[0]); end
            checks++;
            if (obs_q[0] !== 128'h0B0B0B0B0B0B0B0B0B0B0BA5A4A3A2A1) begin
                errors++; $display("FAIL pad_const got %h exp 0B0B0B0B0B0B0B0B0B0B0BA5A4A3A2A1", obs_q[0]);
            end
        end
    endtask

    task automatic test_flush_empty();
        bit seen;
        do_reset();
        drive(1'b0, 8'h00, 1'b1, 1'b1);
        seen = 1'b0;
        for (int c = 0; c < 20; c++) begin
            drive(1'b0, 8'h00, 1'b0, 1'b1);
            @(negedge clk);
            if (block_valid === 1'b1) seen = 1'b1;
        end
        checks++; if (seen) begin errors++; $display("FAIL empty_flush_valid got 1 exp 0"); end
        for (int i = 0; i < 16; i++) begin
            logic [7:0] b;
            b = 8'($urandom_range(0, 255));
            drive(1'b1, b, i == 15, 1'b1);
            xfer_q.push_back(b);
        end
        model_transfer(1'b1);
        for (int c = 0; c < 60 && obs_q.size() < 1; c++) drive(1'b0, 8'h00, 1'b0, 1'b1);
        repeat (10) drive(1'b0, 8'h00, 1'b0, 1'b1);
        checks++; if (obs_q.size() != 1) begin errors++; $display("FAIL exact16_block_count got %0d exp 1", obs_q.size()); end
        checks++; if (obs_q.size() >= 1 && obs_q[0] !== exp_q[0]) begin errors++; $display("FAIL exact16_data got %h exp %h", obs_q[0], exp_q[0]); end
        // Three bytes with no flush must stay parked: a stale pending flush would pad them.
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 8'h50 + 8'(i), 1'b0, 1'b1);
            xfer_q.push_back(8'h50 + 8'(i));
        end
        repeat (30) drive(1'b0, 8'h00, 1'b0, 1'b1);
        checks++; if (obs_q.size() != 1) begin errors++; $display("FAIL stale_flush_count got %0d exp 1", obs_q.size()); end
        drive(1'b0, 8'h00, 1'b1, 1'b1);
        model_transfer(1'b1);
        for (int c = 0; c < 60 && obs_q.size() < 2; c++) drive(1'b0, 8'h00, 1'b0, 1'b1);
        checks++;
        if (obs_q.size() != 2) begin errors++; $display("FAIL late_flush_count got %0d exp 2", obs_q.size()); end
        else if (obs_q[1] !== exp_q[1]) begin errors++; $display("FAIL late_flush_data got %h exp %h", obs_q[1], exp_q[1]); end
    endtask

    task automatic test_overflow();
        do_reset();
        for (int i = 0; i < 49; i++) begin
            drive(1'b1, 8'(i), 1'b0, 1'b0);
            if (i < 48) xfer_q.push_back(8'(i));
        end
        model_transfer(1'b0);
        drive(1'b0, 8'h00, 1'b0, 1'b0);
        @(negedge clk);
        checks++; if (full !== 1'b1) begin errors++; $display("FAIL ovf_full got %b exp 1", full); end
        checks++; if (fifo_count !== 6'd32) begin errors++; $display("FAIL ovf_count got %0d exp 32", fifo_count); end
        checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL ovf_flag got %b exp 1", overflow); end
        checks++; if (block_valid !== 1'b1 || block_data !== exp_q[0]) begin
            errors++; $display("FAIL ovf_hold got v=%b %h exp v=1 %h", block_valid, block_data, exp_q[0]);
        end
        for (int c = 0; c < 200 && obs_q.size() < 3; c++) drive(1'b0, 8'h00, 1'b0, 1'b1);
        repeat (10) drive(1'b0, 8'h00, 1'b0, 1'b1);
        @(negedge clk);
        checks++; if (obs_q.size() != 3) begin errors++; $display("FAIL ovf_block_count got %0d exp 3", obs_q.size()); end
        for (int i = 0; i < 3 && i < obs_q.size(); i++) begin
            checks++;
            if (obs_q[i] !== exp_q[i]) begin errors++; $display("FAIL ovf_block%0d got %h exp %h", i, obs_q[i], exp_q[i]); end
        end
        checks++; if (overflow !== 1'b1 || fifo_count !== '0) begin
            errors++; $display("FAIL ovf_sticky got ovf=%b cnt=%0d exp ovf=1 cnt=0", overflow, fifo_count);
        end
    endtask

    task automatic test_hold_stable();
        bit seen;
        int rise;
        do_reset();
        for (int i = 0; i < 32; i++) begin
            logic [7:0] b;
            b = 8'($urandom_range(0, 255));
            drive(1'b1, b, 1'b0, 1'b0);
            xfer_q.push_back(b);
        end
        model_transfer(1'b0);
        seen = 1'b0;
        for (int c = 0; c < 100; c++) begin
            drive(1'b0, 8'h00, 1'b0, 1'b0);
            @(negedge clk);
            if (block_valid === 1'b1) begin seen = 1'b1; break; end
        end
        checks++; if (!seen) begin errors++; $display("FAIL hold_wait got no block_valid exp 1"); end
        for (int c = 0; c < 10; c++) begin
            drive(1'b0, 8'h00, 1'b0, 1'b0);
            @(negedge clk);
            checks++;
            if (block_valid !== 1'b1 || block_data !== exp_q[0]) begin
                errors++; $display("FAIL hold_stable cycle %0d got v=%b %h exp v=1 %h", c, block_valid, block_data, exp_q[0]);
            end
        end
        drive(1'b0, 8'h00, 1'b0, 1'b1);
        drive(1'b0, 8'h00, 1'b0, 1'b0);
        @(negedge clk);
        checks++; if (block_valid !== 1'b0) begin errors++; $display("FAIL hold_gap got %b exp 0", block_valid); end
        rise = 0;
        for (int c = 2; c < 40; c++) begin
            drive(1'b0, 8'h00, 1'b0, 1'b0);
            @(negedge clk);
            if (block_valid === 1'b1) begin rise = c; break; end
        end
        checks++; if (rise != 18) begin errors++; $display("FAIL hold_next_offset got %0d exp 18", rise); end
        checks++; if (block_data !== exp_q[1]) begin errors++; $display("FAIL hold_next_data got %h exp %h", block_data, exp_q[1]); end
        drive(1'b0, 8'h00, 1'b0, 1'b1);
        drive(1'b0, 8'h00, 1'b0, 1'b0);
    endtask

    task automatic test_reset_mid();
        do_reset();
        for (int i = 0; i < 8; i++) drive(1'b1, 8'hC0 + 8'(i), 1'b0, 1'b1);
        @(posedge clk);
        #3;
        n_rst = 1'b0;
        #1;
        checks++;
        if (block_data !== 128'h0 || block_valid !== 1'b0 || full !== 1'b0 || fifo_count !== '0 || overflow !== 1'b0) begin
            errors++; $display("FAIL midreset_outputs got d=%h v=%b f=%b c=%0d o=%b exp all 0",
                              block_data, block_valid, full, fifo_count, overflow);
        end
        @(posedge clk);
        #1;
        n_rst = 1'b1;
        w_enable = 1'b0;
        obs_q.delete();
        for (int i = 0; i < 16; i++) drive(1'b1, 8'h10 + 8'(i), 1'b0, 1'b1);
        for (int c = 0; c < 60 && obs_q.size() < 1; c++) drive(1'b0, 8'h00, 1'b0, 1'b1);
        repeat (10) drive(1'b0, 8'h00, 1'b0, 1'b1);
        checks++; if (obs_q.size() != 1) begin errors++; $display("FAIL midreset_count got %0d exp 1", obs_q.size()); end
        checks++; if (obs_q.size() >= 1 && obs_q[0] !== 128'h1F1E1D1C1B1A19181716151413121110) begin
            errors++; $display("FAIL midreset_data got %h exp 1F1E1D1C1B1A19181716151413121110", obs_q[0]);
        end
    endtask

    task automatic test_random();
        do_reset();
        for (int t = 0; t < 8; t++) begin
            int len;
            int sent;
            int guard;
            bit fl_last;
            len = (t == 2) ? 16 : (t == 5) ? 32 : $urandom_range(1, 40);
            fl_last = 1'($urandom_range(0, 1));
            sent = 0;
            guard = 0;
            while (sent < len && guard < 2000) begin
                @(posedge clk);
                #1;
                block_ready = 1'($urandom_range(0, 1));
                flush = 1'b0;
                w_enable = 1'b0;
                if (full === 1'b0 && $urandom_range(0, 3) != 0) begin
                    w_enable = 1'b1;
                    w_data = 8'($urandom_range(0, 255));
                    xfer_q.push_back(w_data);
                    sent++;
                    if (sent == len && fl_last) flush = 1'b1;
                end
                guard++;
            end
            if (!fl_last) begin
                repeat ($urandom_range(0, 3)) drive(1'b0, 8'h00, 1'b0, 1'($urandom_range(0, 1)));
                drive(1'b0, 8'h00, 1'b1, 1'($urandom_range(0, 1)));
            end
            model_transfer(1'b1);
            for (int c = 0; c < 3000 && obs_q.size() < exp_q.size(); c++)
                drive(1'b0, 8'h00, 1'b0, 1'($urandom_range(0, 1)));
            repeat (6) drive(1'b0, 8'h00, 1'b0, 1'b1);
            checks++;
            if (obs_q.size() != exp_q.size()) begin
                errors++; $display("FAIL rand_count xfer %0d len %0d got %0d exp %0d", t, len, obs_q.size(), exp_q.size());
            end
        end
        for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
            checks++;
            if (obs_q[i] !== exp_q[i]) begin errors++; $display("FAIL rand_block%0d got %h exp %h", i, obs_q[i], exp_q[i]); end
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_flush_partial();
        test_flush_empty();
        test_overflow();
        test_hold_stable();
        test_reset_mid();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
